domfreq_peak_finder: RTL and testbench

DOMFREQ_PEAK_FINDER -- requirements
Module: domfreq_peak_finder

---
 rtl/domfreq_pkg.sv | 13 +
 rtl/max_tracker.sv | 54 +++++
 rtl/domfreq_peak_finder.sv | 102 ++++++++++
 tb/tb_domfreq_peak_finder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/domfreq_pkg.sv
// Shared defaults and FSM state encoding for the dominant-frequency peak finder.
package domfreq_pkg;

  localparam int BIN_W_DEF = 10;
  localparam int MAG_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/max_tracker.sv
// Running maximum over the candidate bins of one frame; exposes the post-update
// best so the parent can report in the same edge that accepts the final bin.
module max_tracker
  import domfreq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             accept,
  input  logic             restart,
  input  logic             candidate,
  input  logic [BIN_W-1:0] binIdx,
  input  logic [MAG_W-1:0] binMag,
  output logic             nextHas,
  output logic [BIN_W-1:0] nextIdx,
  output logic [MAG_W-1:0] nextMag
);

  logic             hasBest;
  logic [BIN_W-1:0] bestIdx;
  logic [MAG_W-1:0] bestMag;
  logic             baseHas;

  // A restart forgets the previous frame's best before this bin is considered.
  always_comb begin
    baseHas = restart ? 1'b0 : hasBest;
    nextHas = hasBest;
    nextIdx = bestIdx;
    nextMag = bestMag;
    if (accept) begin
      nextHas = baseHas;
      if (candidate && (!baseHas || (binMag > bestMag))) begin
        nextHas = 1'b1;
        nextIdx = binIdx;
        nextMag = binMag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hasBest <= 1'b0;
      bestIdx <= '0;
      bestMag <= '0;
    end else begin
      hasBest <= nextHas;
      bestIdx <= nextIdx;
      bestMag <= nextMag;
    end
  end

endmodule

// File: rtl/domfreq_peak_finder.sv
// Finds the strongest in-window spectrum bin of each frame and reports it once
// per frame when it clears the noise floor.
module domfreq_peak_finder
  import domfreq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bin_valid,
  input  logic [MAG_W-1:0] bin_mag,
  input  logic             bin_last,
  input  logic [BIN_W-1:0] min_bin,
  input  logic [BIN_W-1:0] max_bin,
  input  logic [MAG_W-1:0] noise_floor,
  output logic [BIN_W-1:0] peak,
  output logic [MAG_W-1:0] peak_mag,
  output logic             newDomFreq,
  output logic             frame_err,
  output logic             busy,
  output state_t           dbgState
);

  // Handshake: bin_valid alone qualifies a bin (no ready); bin_last is only
  // meaningful when bin_valid is high.

  state_t           state;
  logic [BIN_W-1:0] binIdx;
  logic [BIN_W-1:0] minQ, maxQ;
  logic [MAG_W-1:0] floorQ;

  logic             overflow, newFrame, candidate;
  logic [BIN_W-1:0] curIdx, effMin, effMax;
  logic [MAG_W-1:0] effFloor;
  logic             nextHas;
  logic [BIN_W-1:0] nextIdx;
  logic [MAG_W-1:0] nextMag;

  // Index 0 uses the live window inputs; later bins use the values sampled then.
  assign overflow  = (state == SCAN) && (binIdx == {BIN_W{1'b1}});
  assign newFrame  = (state != SCAN) || overflow;
  assign curIdx    = newFrame ? '0 : binIdx + 1'b1;
  assign effMin    = newFrame ? min_bin : minQ;
  assign effMax    = newFrame ? max_bin : maxQ;
  assign effFloor  = newFrame ? noise_floor : floorQ;
  assign candidate = (curIdx >= effMin) && (curIdx <= effMax);
  assign busy      = (state == SCAN);
  assign dbgState  = state;

  max_tracker #(.BIN_W(BIN_W), .MAG_W(MAG_W)) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .accept    (bin_valid),
    .restart   (newFrame),
    .candidate (candidate),
    .binIdx    (curIdx),
    .binMag    (bin_mag),
    .nextHas   (nextHas),
    .nextIdx   (nextIdx),
    .nextMag   (nextMag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      binIdx     <= '0;
      minQ       <= '0;
      maxQ       <= '0;
      floorQ     <= '0;
      peak       <= '0;
      peak_mag   <= '0;
      newDomFreq <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      newDomFreq <= 1'b0;
      frame_err  <= 1'b0;
      if (bin_valid) begin
        binIdx    <= curIdx;
        frame_err <= overflow;
        if (newFrame) begin
          minQ   <= min_bin;
          maxQ   <= max_bin;
          floorQ <= noise_floor;
        end
        if (bin_last) begin
          state <= REPORT;
          if (nextHas && (nextMag >= effFloor)) begin
            peak       <= nextIdx;
            peak_mag   <= nextMag;
            newDomFreq <= 1'b1;
          end
        end else begin
          state <= SCAN;
        end
      end else if (state == REPORT) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_domfreq_peak_finder.sv
// Randomized bench for domfreq_peak_finder against a frame-level reference model.
module tb_domfreq_peak_finder;
  import domfreq_pkg::*;

  localparam int BIN_W = 10;
  localparam int MAG_W = 16;
  localparam int NBINS = 1 << BIN_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             bin_valid = 1'b0;
  logic [MAG_W-1:0] bin_mag = '0;
  logic             bin_last = 1'b0;
  logic [BIN_W-1:0] min_bin = '0;
  logic [BIN_W-1:0] max_bin = '0;
  logic [MAG_W-1:0] noise_floor = '0;
  logic [BIN_W-1:0] peak;
  logic [MAG_W-1:0] peak_mag;
  logic             newDomFreq, frame_err, busy;
  state_t           dbgState;

  domfreq_peak_finder #(.BIN_W(BIN_W), .MAG_W(MAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .bin_valid(bin_valid), .bin_mag(bin_mag),
    .bin_last(bin_last), .min_bin(min_bin), .max_bin(max_bin),
    .noise_floor(noise_floor), .peak(peak), .peak_mag(peak_mag),
    .newDomFreq(newDomFreq), .frame_err(frame_err), .busy(busy),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: bins of the open frame plus the frame's window.
  int   q[$];
  int   wLo, wHi, wFl;
  bit   expStrobe = 0, expErr = 0, expBusy = 0;
  int   expPeak = 0, expPeakMag = 0;
  logic [MAG_W-1:0] fm[0:NBINS+15];

  task automatic check_outputs(input string tag);
    vectors += 5;
    if (newDomFreq !== expStrobe) begin
      miscompares++; $display("FAIL %s newDomFreq got %0b exp %0b t=%0t", tag, newDomFreq, expStrobe, $time);
    end
    if (frame_err !== expErr) begin
      miscompares++; $display("FAIL %s frame_err got %0b exp %0b t=%0t", tag, frame_err, expErr, $time);
    end
    if (busy !== expBusy) begin
      miscompares++; $display("FAIL %s busy got %0b exp %0b t=%0t", tag, busy, expBusy, $time);
    end
    if (peak !== expPeak[BIN_W-1:0]) begin
      miscompares++; $display("FAIL %s peak got %0d exp %0d t=%0t", tag, peak, expPeak, $time);
    end
    if (peak_mag !== expPeakMag[MAG_W-1:0]) begin
      miscompares++; $display("FAIL %s peak_mag got %0d exp %0d t=%0t", tag, peak_mag, expPeakMag, $time);
    end
  endtask

  // One clock: check what the previous cycle should have produced, drive, predict.
  task automatic step(input bit v, input logic [MAG_W-1:0] m, input bit l,
                      input int lo, input int hi, input int fl, input string tag);
    int bestI;
    @(negedge clk);
    check_outputs(tag);
    bin_valid   = v;
    bin_mag     = m;
    bin_last    = l;
    min_bin     = lo[BIN_W-1:0];
    max_bin     = hi[BIN_W-1:0];
    noise_floor = fl[MAG_W-1:0];
    expStrobe = 0;
    expErr    = 0;
    if (v) begin
      if (q.size() == NBINS) begin
        expErr = 1;
        q.delete();
      end
      if (q.size() == 0) begin
        wLo = int'(min_bin); wHi = int'(max_bin); wFl = int'(noise_floor);
      end
      q.push_back(int'(m));
      if (l) begin
        bestI = -1;
        for (int k = 0; k < q.size(); k++)
          if (k >= wLo && k <= wHi && (bestI < 0 || q[k] > q[bestI])) bestI = k;
        if (bestI >= 0 && q[bestI] >= wFl) begin
          expStrobe  = 1;
          expPeak    = bestI;
          expPeakMag = q[bestI];
        end
        q.delete();
      end
    end
    expBusy = (q.size() != 0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step(0, MAG_W'($urandom), 1'($urandom), $urandom, $urandom, $urandom, tag);
  endtask

  // Sends fm[0..n-1]; window inputs scramble after bin 0 to prove they are held.
  task automatic send_frame(input int n, input int lo, input int hi, input int fl,
                            input int maxGap, input bit withLast, input string tag);
    for (int i = 0; i < n; i++) begin
      if (maxGap > 0) begin
        int g;
        g = $urandom_range(maxGap, 0);
        idle_cycles(g, tag);
      end
      if (i == 0) step(1, fm[0], withLast && (n == 1), lo, hi, fl, tag);
      else        step(1, fm[i], withLast && (i == n - 1), $urandom, $urandom, $urandom, tag);
    end
  endtask

  task automatic load_basic();
    int m[8] = '{3, 9, 4, 9, 1, 0, 2, 5};
    for (int i = 0; i < 8; i++) fm[i] = MAG_W'(m[i]);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    load_basic();
    send_frame(8, 0, 7, 2, 0, 1, "win0_7");
    idle_cycles(2, "win0_7");
    if (expPeak != 1 || expPeakMag != 9) begin
      miscompares++; $display("FAIL model_win0_7 peak %0d/%0d exp 1/9", expPeak, expPeakMag);
    end
    vectors++;
    send_frame(8, 2, 6, 2, 0, 1, "win2_6");
    idle_cycles(2, "win2_6");
    send_frame(8, 2, 6, 10, 0, 1, "floor10");
    idle_cycles(2, "floor10");
    send_frame(8, 6, 2, 0, 0, 1, "min_gt_max");
    idle_cycles(2, "min_gt_max");
    send_frame(1, 0, 0, 0, 0, 1, "one_bin");
    idle_cycles(1, "one_bin");
  endtask

  task automatic test_gaps();
    load_basic();
    for (int r = 0; r < 4; r++) begin
      send_frame(8, 0, 7, 2, 3, 1, "gaps");
      idle_cycles(1, "gaps");
      send_frame(8, 2, 6, 2, 3, 1, "gaps26");
      idle_cycles(1, "gaps26");
    end
  endtask

  task automatic test_back_to_back();
    load_basic();
    send_frame(8, 0, 7, 2, 0, 1, "b2b_a");
    fm[0] = 16'd1; fm[1] = 16'd7; fm[2] = 16'd7; fm[3] = 16'd2;
    send_frame(4, 0, 3, 1, 0, 1, "b2b_b");
    send_frame(4, 1, 3, 0, 0, 1, "b2b_c");
    idle_cycles(2, "b2b_tail");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < NBINS; i++) fm[i] = MAG_W'($urandom_range(200, 0));
    send_frame(NBINS, 0, NBINS - 1, 0, 0, 0, "ovf_long");
    fm[0] = 16'd4; fm[1] = 16'd11; fm[2] = 16'd3; fm[3] = 16'd8;
    send_frame(4, 0, 3, 1, 0, 1, "ovf_next");
    idle_cycles(2, "ovf_tail");
  endtask

  task automatic test_reset_mid_scan();
    load_basic();
    send_frame(5, 0, 7, 0, 0, 0, "mid_scan");
    #2 reset_n = 1'b0;
    q.delete();
    expStrobe = 0; expErr = 0; expBusy = 0; expPeak = 0; expPeakMag = 0;
    bin_valid = 1'b0;
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    fm[0] = 16'd6; fm[1] = 16'd2; fm[2] = 16'd6;
    send_frame(3, 0, 2, 1, 0, 1, "after_reset");
    idle_cycles(2, "after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) fm[i] = MAG_W'($urandom_range(15, 0));
      send_frame(n, $urandom_range(24, 0), $urandom_range(24, 0), $urandom_range(12, 0),
                 $urandom_range(2, 0), 1, "random");
    end
    idle_cycles(2, "random_tail");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached at t=%0t", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
